// File: rtl/dtpu_infifo_bridge.sv
// dtpu_infifo_bridge: AXI-stream slave to acc_fifo_read style FWFT FIFO for the DTPU input stream.
// Latency: a word accepted on cycle N is visible on rd_data/empty_n in cycle N+1 (no bypass).
// Backpressure: s_axis_tready drops when DEPTH words are held or during flush; it never depends on rd_en.
//
// Ports: clk/aresetn (async active-low), flush (sync clear), s_axis_tdata/tvalid/tready (stream in),
//        rd_data/rd_en/empty_n (FWFT read side), underflow (sticky: rd_en seen while empty).
// Optional: define DTPU_INFIFO_LEVEL_EN to add level (registered count) and overflow_attempt
//        (sticky: tvalid while full, cleared by reset or flush).
module dtpu_infifo_bridge #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         rd_data,
  input  logic                          rd_en,
  output logic                          empty_n,
  output logic                          underflow
`ifdef DTPU_INFIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow_attempt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] rd_hold;
  logic                  rst_done;
  logic                  push;
  logic                  pop;

  // rst_done keeps tready low while in reset and until the first edge after release.
  assign s_axis_tready = rst_done && (count != FULL_CNT) && !flush;
  assign empty_n       = (count != '0);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = rd_en && empty_n && !flush;

  // FWFT: show the head word while non-empty, otherwise the last word shown.
  // rd_hold is reset, so rd_data reads 0 immediately on reset (count is 0).
  assign rd_data = empty_n ? mem[rd_ptr] : rd_hold;

  // Storage has no reset so it can map to distributed RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rst_done <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_hold  <= '0;
    end else begin
      rst_done <= 1'b1;
      if (empty_n) begin
        rd_hold <= mem[rd_ptr];
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Sticky; a flush cycle neither sets nor clears it.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      underflow <= 1'b0;
    end else if (rd_en && !empty_n && !flush) begin
      underflow <= 1'b1;
    end
  end

`ifdef DTPU_INFIFO_LEVEL_EN
  assign level = count;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      overflow_attempt <= 1'b0;
    end else if (flush) begin
      overflow_attempt <= 1'b0;
    end else if (s_axis_tvalid && (count == FULL_CNT)) begin
      overflow_attempt <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dtpu_infifo_bridge.sv
// Testbench for dtpu_infifo_bridge (DEPTH=16, DATA_WIDTH=64): directed table, corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_dtpu_infifo_bridge;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        flush;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] rd_data;
  logic        rd_en;
  logic        empty_n;
  logic        underflow;
`ifdef DTPU_INFIFO_LEVEL_EN
  logic [4:0]  level;
  logic        overflow_attempt;
`endif

  dtpu_infifo_bridge #(.DATA_WIDTH(64), .DEPTH(16)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .flush         (flush),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .rd_data       (rd_data),
    .rd_en         (rd_en),
    .empty_n       (empty_n),
    .underflow     (underflow)
`ifdef DTPU_INFIFO_LEVEL_EN
    ,
    .level            (level),
    .overflow_attempt (overflow_attempt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO contents as a queue plus a few flags.
  logic [63:0] q[$];
  bit          m_uf;
  bit          m_ovf;
  bit          started;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_rdy();
    return started && (q.size() < 16) && !flush;
  endfunction

  task automatic model_reset();
    q.delete();
    m_uf    = 0;
    m_ovf   = 0;
    started = 0;
  endtask

  // Drive inputs, then compare outputs against the model at the falling edge.
  task automatic apply(input bit f, input bit v, input logic [63:0] d, input bit r);
    flush = f; s_axis_tvalid = v; s_axis_tdata = d; rd_en = r;
    @(negedge clk);
    chk("tready", {63'd0, s_axis_tready}, {63'd0, exp_rdy()});
    chk("empty_n", {63'd0, empty_n}, {63'd0, q.size() != 0});
    chk("underflow", {63'd0, underflow}, {63'd0, m_uf});
    if (q.size() != 0) chk("rd_data", rd_data, q[0]);
`ifdef DTPU_INFIFO_LEVEL_EN
    chk("level", {59'd0, level}, 64'(q.size()));
    chk("overflow_attempt", {63'd0, overflow_attempt}, {63'd0, m_ovf});
`endif
  endtask

  // Advance one clock edge and update the model from the inputs seen at that edge.
  task automatic commit();
    bit p_push, p_pop;
    @(posedge clk);
    if (aresetn) begin
      if (flush) begin
        q.delete();
        m_ovf = 0;
      end else begin
        p_push = s_axis_tvalid && exp_rdy();
        p_pop  = rd_en && (q.size() != 0);
        if (rd_en && q.size() == 0) m_uf = 1;
        if (s_axis_tvalid && q.size() == 16) m_ovf = 1;
        if (p_pop) void'(q.pop_front());
        if (p_push) q.push_back(s_axis_tdata);
      end
      started = 1;
    end
    #1;
  endtask

  task automatic cyc(input bit f, input bit v, input logic [63:0] d, input bit r);
    apply(f, v, d, r);
    commit();
  endtask

  typedef struct {
    bit          f, v, r;
    logic [63:0] d;
    bit          e_rdy, e_en;
    logic [63:0] e_rd;
  } vec_t;

  vec_t tab[11];

  initial begin
    // In-order transfer: push 0..4 back to back, then pop continuously.
    //          f  v  r  d       rdy en  rd
    tab[0]  = '{0, 1, 0, 64'h0, 1, 0, 64'h0};
    tab[1]  = '{0, 1, 0, 64'h1, 1, 1, 64'h0};
    tab[2]  = '{0, 1, 0, 64'h2, 1, 1, 64'h0};
    tab[3]  = '{0, 1, 0, 64'h3, 1, 1, 64'h0};
    tab[4]  = '{0, 1, 0, 64'h4, 1, 1, 64'h0};
    tab[5]  = '{0, 0, 1, 64'h0, 1, 1, 64'h0};
    tab[6]  = '{0, 0, 1, 64'h0, 1, 1, 64'h1};
    tab[7]  = '{0, 0, 1, 64'h0, 1, 1, 64'h2};
    tab[8]  = '{0, 0, 1, 64'h0, 1, 1, 64'h3};
    tab[9]  = '{0, 0, 1, 64'h0, 1, 1, 64'h4};
    tab[10] = '{0, 0, 0, 64'h0, 1, 0, 64'h0};

    aresetn = 1'b0; flush = 0; s_axis_tvalid = 0; s_axis_tdata = '0; rd_en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", {63'd0, s_axis_tready}, 64'd0);
    chk("rst_empty_n", {63'd0, empty_n}, 64'd0);
    chk("rst_underflow", {63'd0, underflow}, 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    apply(0, 0, 0, 0);
    chk("tready_before_edge", {63'd0, s_axis_tready}, 64'd0);
    commit();

    for (int i = 0; i < 11; i++) begin
      apply(tab[i].f, tab[i].v, tab[i].d, tab[i].r);
      chk($sformatf("tab%0d_tready", i), {63'd0, s_axis_tready}, {63'd0, tab[i].e_rdy});
      chk($sformatf("tab%0d_empty_n", i), {63'd0, empty_n}, {63'd0, tab[i].e_en});
      if (tab[i].e_en) chk($sformatf("tab%0d_rd_data", i), rd_data, tab[i].e_rd);
      commit();
    end

    // Underflow: rd_en while empty sets the sticky flag, later traffic keeps it.
    cyc(0, 0, 0, 1);
    apply(0, 0, 0, 0);
    chk("underflow_set", {63'd0, underflow}, 64'd1);
    commit();
    cyc(0, 1, 64'h77, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    apply(0, 0, 0, 0);
    chk("underflow_sticky", {63'd0, underflow}, 64'd1);
    commit();

    // Fill to full, refused 17th word, pop frees a slot for it.
    for (int i = 0; i < 16; i++) cyc(0, 1, 64'h100 + 64'(i), 0);
    apply(0, 1, 64'h1FF, 0);
    chk("full_tready", {63'd0, s_axis_tready}, 64'd0);
    commit();
    cyc(0, 1, 64'h1FF, 1);
    apply(0, 1, 64'h1FF, 0);
    chk("tready_after_pop", {63'd0, s_axis_tready}, 64'd1);
    commit();
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1);
    apply(0, 0, 0, 1);
    chk("word17_last", rd_data, 64'h1FF);
    commit();

    // Simultaneous push/pop at count 8, then 40 words streamed through the wrap.
    for (int i = 0; i < 8; i++) cyc(0, 1, 64'h300 + 64'(i), 0);
    for (int i = 0; i < 40; i++) cyc(0, 1, 64'h400 + 64'(i), 1);
    apply(0, 0, 0, 0);
    chk("cnt8_head", rd_data, 64'h420);
    commit();
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);

    // Flush with 7 words and tvalid high.
    for (int i = 0; i < 7; i++) cyc(0, 1, 64'h500 + 64'(i), 0);
    cyc(1, 1, 64'hDEAD, 0);
    apply(0, 0, 0, 0);
    chk("flush_empty_n", {63'd0, empty_n}, 64'd0);
    commit();
    cyc(0, 1, 64'h55, 0);
    apply(0, 0, 0, 0);
    chk("after_flush_first", rd_data, 64'h55);
    commit();
    cyc(0, 0, 0, 1);

    // Async reset mid-cycle with 5 words stored.
    for (int i = 0; i < 5; i++) cyc(0, 1, 64'h600 + 64'(i), 0);
    s_axis_tvalid = 0;
    #2 aresetn = 1'b0;
    #1;
    chk("arst_empty_n", {63'd0, empty_n}, 64'd0);
    chk("arst_tready", {63'd0, s_axis_tready}, 64'd0);
    chk("arst_underflow", {63'd0, underflow}, 64'd0);
    chk("arst_rd_data", rd_data, 64'd0);
    model_reset();
    @(posedge clk); #1;
    aresetn = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 1, 64'hAA, 0);
    apply(0, 0, 0, 0);
    chk("post_reset_first", rd_data, 64'hAA);
    commit();

    // Randomized traffic; the pop probability drifts so the FIFO visits empty and full.
    for (int blk = 0; blk < 12; blk++) begin
      int pop_pct = (blk % 3 == 0) ? 20 : (blk % 3 == 1) ? 85 : 50;
      for (int i = 0; i < 200; i++) begin
        bit f = ($urandom_range(0, 79) == 0);
        bit v = ($urandom_range(0, 99) < 70);
        bit r = ($urandom_range(0, 99) < pop_pct);
        cyc(f, v, {$urandom, $urandom}, r);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dtpu_infifo_bridge.md
DTPU_INFIFO_BRIDGE -- requirements
Module: dtpu_infifo_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of stream and read data.
REQ-002 SHALL have parameter DEPTH, default 16, number of storage words; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port aresetn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port flush, input, 1, synchronous clear of stored words.
REQ-006 SHALL have port s_axis_tdata, input, DATA_WIDTH, AXI-stream slave data from the PS DMA.
REQ-007 SHALL have port s_axis_tvalid, input, 1, AXI-stream valid.
REQ-008 SHALL have port s_axis_tready, output, 1, AXI-stream ready.
REQ-009 SHALL have port rd_data, output, DATA_WIDTH, acc_fifo_read RD_DATA toward the core's infifo_dout.
REQ-010 SHALL have port rd_en, input, 1, acc_fifo_read RD_EN, the pop request from the core.
REQ-011 SHALL have port empty_n, output, 1, acc_fifo_read EMPTY_N; high means rd_data holds a valid word.
REQ-012 SHALL have port underflow, output, 1, sticky flag: rd_en was seen while empty_n was low.

Function
REQ-013 SHALL store words in a DEPTH-entry circular buffer addressed by write and read pointers, each log2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-014 SHALL keep an occupancy count of log2(DEPTH)+1 bits, ranging 0..DEPTH.
REQ-015 SHALL drive s_axis_tready = (count != DEPTH) AND NOT flush, from registered state only, with no combinational path from rd_en.
REQ-016 SHALL perform a push when s_axis_tvalid AND s_axis_tready: write tdata at the write pointer and advance it.
REQ-017 SHALL drive empty_n = (count != 0), registered-state derived.
REQ-018 SHALL present the word at the read pointer on rd_data whenever empty_n is high (first-word-fall-through).
REQ-019 SHALL perform a pop when rd_en AND empty_n: advance the read pointer; the next word, if any, appears on rd_data the following cycle.
REQ-020 SHALL give a push-to-read latency of one cycle: a word accepted in cycle N raises empty_n in cycle N+1; there is no bypass.
REQ-021 SHALL, on simultaneous push and pop, update both pointers and leave count unchanged; this is legal at any count 1..DEPTH-1.
REQ-022 SHALL, when full, hold s_axis_tready low; a pop in that cycle frees space and tready rises the next cycle.
REQ-023 SHALL, when empty and rd_en is high, leave pointers and count unchanged and set underflow to 1 the next cycle.
REQ-024 SHALL hold rd_data at its last value while empty_n is low; the value is don't-care for checking.
REQ-025 SHALL, on flush high, zero both pointers and count the next cycle, ignore push and pop in that cycle, and leave underflow unchanged.
REQ-026 SHALL clear underflow only by reset.
REQ-027 SHALL leave the stored-data array uninitialised, with no reset on the storage, so it maps to distributed RAM.

Reset
REQ-028 SHALL, while aresetn is low, immediately force: pointers 0, count 0, empty_n 0, s_axis_tready 0, underflow 0, rd_data 0.
REQ-029 SHALL, on assertion of aresetn mid-transfer, discard all stored words; the first stream word after release is the first word read.
REQ-030 SHALL raise s_axis_tready no earlier than the first clk edge after aresetn is released.

Configuration
REQ-031 SHALL, when macro DTPU_INFIFO_LEVEL_EN is defined, add output port level (log2(DEPTH)+1 bits, equal to the registered count) and output port overflow_attempt (sticky, set when s_axis_tvalid is high while count == DEPTH, cleared by reset or flush).
REQ-032 SHALL, without DTPU_INFIFO_LEVEL_EN, omit both ports and their logic, with all other behaviour identical.

Verification (DEPTH=16, DATA_WIDTH=64)
REQ-033 SHALL cover in-order transfer: push 0x0..0x4 back-to-back, then pop continuously -> empty_n rises one cycle after the first push; rd_data reads 0x0..0x4 in order; empty_n falls after the 5th pop.
REQ-034 SHALL cover fill to full: 16 pushes with no rd_en -> tready low at count 16 and the 17th word is not accepted; one pop -> tready high the next cycle and the 17th word is accepted.
REQ-035 SHALL cover simultaneous push/pop at count 16 (tready low, so pop only) and at count 8 (push and pop) -> count 15 and count 8 respectively; data order is preserved across pointer wrap after 40 words.
REQ-036 SHALL cover underflow: rd_en pulse with count 0 -> underflow=1 the next cycle, pointers unchanged; a later valid push/pop leaves underflow at 1.
REQ-037 SHALL cover flush with count 7 and tvalid high -> the next cycle count=0, empty_n=0, the push in the flush cycle is not stored, and the next accepted word is read first.
REQ-038 SHALL cover async reset asserted mid-cycle with count 5 -> empty_n=0 and tready=0 without waiting for a clock edge; after release, push 0xAA -> rd_data 0xAA.
